// File: rtl/rca_seq_ctrl.sv
// Serial adder: one 2-bit ripple-carry slice walks the operands LSB pair first,
// with a valid/ready handshake on both the operand and the result side.
module rca_seq_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
);

  localparam int unsigned PAIRS = WIDTH / 2;
  localparam int unsigned CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [CW-1:0] LAST = CW'(PAIRS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sum_q;
  logic [WIDTH:0]   sum_nxt;
  logic             accept;
  logic             step;
  logic             last;
  logic             s0;
  logic             c0;
  logic             s1;
  logic             cout;

  // 2-bit ripple-carry slice on the low pair of the shift registers
  always_comb begin
    s0   = a_sh[0] ^ b_sh[0] ^ carry;
    c0   = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    s1   = a_sh[1] ^ b_sh[1] ^ c0;
    cout = (a_sh[1] & b_sh[1]) | (c0 & (a_sh[1] ^ b_sh[1]));
  end

  assign last = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sum_nxt = sum_q;
    for (int unsigned k = 0; k < PAIRS; k++) begin
      if (cnt == CW'(k)) begin
        sum_nxt[2*k +: 2] = {s1, s0};
      end
    end
    if (last) begin
      sum_nxt[WIDTH] = cout;
    end
  end

  // The counter holds on the final pair so it never wraps inside an operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum_q <= '0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (step) begin
      sum_q <= sum_nxt;
      carry <= cout;
      a_sh  <= a_sh >> 2;
      b_sh  <= b_sh >> 2;
      if (!last) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign sum = sum_q;

endmodule

// File: doc/rca_seq_ctrl.md
RCA_SEQ_CTRL -- requirements
Module: rca_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand width in bits; legal values are even and at least 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operands and carry-in are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: the addends.
REQ-007 The block SHALL have port cin, input, 1 bit: carry into bit 0.
REQ-008 The block SHALL have port out_valid, output, 1 bit: sum is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts sum.
REQ-010 The block SHALL have port sum, output, WIDTH+1 bits: a+b+cin, with bit WIDTH as the carry-out.

Function
REQ-011 The block SHALL compute the sum serially through one internal 2-bit ripple-carry slice (s0=x0^y0^c; c0=x0&y0 | c&(x0^y0); s1=x1^y1^c0; cout=x1&y1 | c0&(x1^y1)), two bit positions per RUN cycle, LSB pair first.
REQ-012 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-013 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-014 In IDLE, on in_valid=1 the block SHALL capture a, b and cin into internal shift/carry registers, clear the pair counter to 0, and enter RUN (accept edge).
REQ-015 In RUN, in_ready and out_valid SHALL be 0.
REQ-016 In RUN, each edge SHALL process one bit pair: write the two slice sum bits to sum[2k+1:2k] (k = counter), update the carry register with cout, shift both operand registers right by 2, and increment the counter.
REQ-017 When the counter equals WIDTH/2-1 in RUN, that edge SHALL also write cout into sum[WIDTH] and enter DONE.
REQ-018 out_valid SHALL therefore rise exactly WIDTH/2 rising edges after the accept edge (4 edges for WIDTH=8).
REQ-019 In DONE, out_valid SHALL be 1, in_ready SHALL be 0, and sum SHALL hold stable until out_ready=1.
REQ-020 An edge with out_valid=1 and out_ready=1 SHALL return the FSM to IDLE; sum SHALL retain its value but is defined only while out_valid=1.
REQ-021 in_valid SHALL be ignored in RUN and DONE, with no capture and no effect on the computation in progress.
REQ-022 Changes on a, b or cin after the accept edge SHALL NOT affect the result.
REQ-023 There SHALL be no back-to-back acceptance in the same edge as output handoff; the next accept can occur no earlier than the edge after returning to IDLE.
REQ-024 Arithmetic SHALL be unsigned modulo 2^(WIDTH+1) with no overflow flag; carry-out is carried only in sum[WIDTH].
REQ-025 The counter SHALL be ceil(log2(WIDTH/2)) bits wide, minimum 1 bit, and SHALL never wrap within one operation.

Reset
REQ-026 While rst_n=0, the block SHALL immediately, without waiting for a clock edge, force: state=IDLE, in_ready=1, out_valid=0, sum=0, counter=0, carry register=0, and operand registers=0.
REQ-027 Assertion of rst_n=0 in RUN or DONE SHALL abort the operation with no partial result presented afterwards.
REQ-028 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Verification (WIDTH=8)
REQ-029 Bench SHALL apply a=0x5A, b=0x3C, cin=0, out_ready=1 and SHALL observe out_valid high after 4 edges with sum=0x096, then in_ready=1 on the following cycle.
REQ-030 Bench SHALL apply a=0xFF, b=0x01, cin=0 and SHALL observe sum=0x100 (full carry ripple across all pairs).
REQ-031 Bench SHALL apply a=0xFF, b=0xFF, cin=1 and SHALL observe sum=0x1FF; a separate run with a=0x00, b=0x00, cin=0 SHALL give sum=0x000.
REQ-032 Bench SHALL hold out_ready=0 for 3 cycles in DONE after 0x12+0x34 and SHALL observe out_valid=1 and sum=0x046 held for those 3 cycles, then IDLE one edge after out_ready=1.
REQ-033 Bench SHALL pulse in_valid with a=0x01, b=0x01 during RUN of 0x80+0x80 and SHALL observe result 0x100 with no second result produced.
REQ-034 Bench SHALL drop rst_n low mid-RUN (after 2 edges) and SHALL observe out_valid=0, in_ready=1 and sum=0 immediately; a new operation 0x0F+0x01 afterwards SHALL give 0x010.
